// File: rtl/btpipe_pkg.sv
// Shared definitions for the block-throttled output pipe arbiter.
//   state_t : arbiter FSM state encoding
//   WORD_W  : width of one pipe word
package btpipe_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ARMED = 2'd2,
        ST_XFER  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin source selector (purely combinational).
//   req   : per-source request vector
//   ptr   : index of the most recently served source
//   grant : first requesting source found scanning from ptr+1 (mod N)
//   valid : at least one request is present
module rr_select #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   grant,
    output logic         valid
);

    // Scan offsets from farthest to nearest so the nearest requester
    // (smallest offset after ptr) is the last, and therefore winning, write.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = 2'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btpipe_out_arbiter.sv
// Arbitrates several FWFT source FIFOs onto one block-throttled output pipe.
// A source is granted only when it holds a full block; the endpoint then
// drains exactly BLOCK_WORDS words from it before re-arbitration.
//   okClk, rst_n        : clock, async active-low reset
//   src_enable          : per-source arbitration enable
//   src_count, src_data : per-source FIFO occupancy and head word
//   src_pop             : one-hot pop to the granted source (same cycle as ep_read)
//   ep_read             : endpoint word read strobe
//   ep_blockstrobe      : endpoint block-start strobe
//   ep_ready            : a full block is armed
//   ep_datain           : word returned to the endpoint (valid cycle after ep_read)
//   active_src          : granted source index
//   block_done          : pulse on the last word of a block
//   err_clr             : clear error flags
//   err_overrun         : sticky, ep_read seen outside a transfer
//   err_underrun        : sticky, ep_read while the granted FIFO was empty
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | just out of reset, moves to ST_ARB next cycle
// ST_ARB   | looking for an enabled source holding a full block
// ST_ARMED | source latched, ep_ready high, waiting for ep_blockstrobe
// ST_XFER  | block in progress, one pop per ep_read
module btpipe_out_arbiter
    import btpipe_pkg::*;
#(
    parameter int NSRC        = 2,
    parameter int BLOCK_WORDS = 256,
    parameter int CW          = 16
) (
    input  logic                   okClk,
    input  logic                   rst_n,
    input  logic [NSRC-1:0]        src_enable,
    input  logic [NSRC*CW-1:0]     src_count,
    input  logic [NSRC*WORD_W-1:0] src_data,
    output logic [NSRC-1:0]        src_pop,
    input  logic                   ep_read,
    input  logic                   ep_blockstrobe,
    output logic                   ep_ready,
    output logic [WORD_W-1:0]      ep_datain,
    output logic [1:0]             active_src,
    output logic                   block_done,
    input  logic                   err_clr,
    output logic                   err_overrun,
    output logic                   err_underrun
);

    localparam int CNTW = $clog2(BLOCK_WORDS) + 1;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [CNTW-1:0]   word_cnt;
    logic [CNTW-1:0]   word_cnt_nxt;

    logic [NSRC-1:0]   eligible;
    logic [1:0]        grant;
    logic              grant_valid;

    logic [CW-1:0]     act_count;
    logic [WORD_W-1:0] act_data;
    logic              xfer_read;
    logic              act_empty;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = src_enable[i] &&
                          (src_count[i*CW +: CW] >= CW'(BLOCK_WORDS));
        end
    end

    rr_select #(.N(NSRC)) u_rr_select (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        act_count = '0;
        act_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (active_src == 2'(i)) begin
                act_count = src_count[i*CW +: CW];
                act_data  = src_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign xfer_read    = (state == ST_XFER) && ep_read;
    assign act_empty    = (act_count == '0);
    assign word_cnt_nxt = word_cnt + 1'b1;

    // Pop must coincide with ep_read so the FWFT head advances in step with
    // the word registered into ep_datain; an empty FIFO is never popped.
    always_comb begin
        src_pop = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (xfer_read && !act_empty && active_src == 2'(i)) begin
                src_pop[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ep_ready     <= 1'b0;
            ep_datain    <= '0;
            active_src   <= '0;
            rr_ptr       <= 2'(NSRC - 1);
            word_cnt     <= '0;
            block_done   <= 1'b0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            block_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    state <= ST_ARB;
                end
                ST_ARB: begin
                    if (grant_valid) begin
                        active_src <= grant;
                        ep_ready   <= 1'b1;
                        state      <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (ep_blockstrobe) begin
                        ep_ready <= 1'b0;
                        word_cnt <= '0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (ep_read) begin
                        ep_datain <= act_data;
                        word_cnt  <= word_cnt_nxt;
                        if (word_cnt_nxt == CNTW'(BLOCK_WORDS)) begin
                            block_done <= 1'b1;
                            rr_ptr     <= active_src;
                            state      <= ST_ARB;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (ep_read && state != ST_XFER) begin
                ep_datain <= '0;
            end

            // Clear first so a same-cycle error event overrides it.
            if (err_clr) begin
                err_overrun  <= 1'b0;
                err_underrun <= 1'b0;
            end
            if (ep_read && state != ST_XFER) begin
                err_overrun <= 1'b1;
            end
            if (xfer_read && act_empty) begin
                err_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/btpipe_out_arbiter.md
BTPIPE_OUT_ARBITER -- requirements
Module: btpipe_out_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 2, giving the number of source FIFOs (2..4) sharing one block-throttled output pipe.
REQ-002 SHALL have parameter BLOCK_WORDS, default 256, giving the 32-bit words per block (power of 2, 4..1024).
REQ-003 SHALL have parameter CW, default 16, giving the width of each source occupancy count.
REQ-004 SHALL have port okClk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port src_enable, input, NSRC: per-source arbitration enable.
REQ-007 SHALL have port src_count, input, NSRC*CW: per-source FWFT FIFO occupancy in words.
REQ-008 SHALL have port src_data, input, NSRC*32: per-source FWFT head word.
REQ-009 SHALL have port src_pop, output, NSRC: one-hot pop strobe to the granted source.
REQ-010 SHALL have port ep_read, input, 1: word read strobe from the pipe endpoint.
REQ-011 SHALL have port ep_blockstrobe, input, 1: block-start strobe from the pipe endpoint.
REQ-012 SHALL have port ep_ready, output, 1: a full block is available.
REQ-013 SHALL have port ep_datain, output, 32: word returned to the endpoint.
REQ-014 SHALL have port active_src, output, 2: index of the currently granted source.
REQ-015 SHALL have port block_done, output, 1: one-cycle pulse on the last word of a block.
REQ-016 SHALL have port err_clr, input, 1: clears the error flags.
REQ-017 SHALL have ports err_overrun and err_underrun, outputs, 1 each: sticky protocol error flags.

Function
REQ-018 SHALL implement states IDLE, ARB, ARMED, XFER.
REQ-019 IDLE SHALL advance to ARB on the next cycle.
REQ-020 ARB SHALL pick, round-robin starting at rr_ptr+1 mod NSRC, the first source with src_enable=1 and src_count>=BLOCK_WORDS; then latch active_src and go to ARMED; with no eligible source it SHALL stay in ARB.
REQ-021 ARMED SHALL drive ep_ready=1 (registered); ep_ready SHALL be 0 in all other states.
REQ-022 ep_blockstrobe in ARMED SHALL move to XFER and clear the word counter.
REQ-023 In XFER, each ep_read SHALL assert src_pop[active_src] in the same cycle and register src_data[active_src] into ep_datain on that edge (data valid the cycle after ep_read).
REQ-024 The word counter (log2(BLOCK_WORDS)+1 bits) SHALL increment per ep_read.
REQ-025 On the read that makes count=BLOCK_WORDS: pulse block_done, set rr_ptr=active_src, go to ARB.
REQ-026 ep_read outside XFER SHALL set err_overrun, leave src_pop at 0, and load ep_datain with 0.
REQ-027 ep_read when src_count[active_src]=0 SHALL set err_underrun and suppress src_pop; the counter still advances.
REQ-028 ep_blockstrobe outside ARMED SHALL be ignored.
REQ-029 src_enable deasserting for the granted source mid-block SHALL NOT abort the block.
REQ-030 err_clr SHALL clear both flags; an error event in the same cycle SHALL win (flag stays 1).
REQ-031 ep_datain SHALL hold its value between reads.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, ep_ready 0, ep_datain 0, src_pop 0, active_src 0, rr_ptr NSRC-1 (so source 0 is checked first), counter 0, block_done 0, both error flags 0.
REQ-033 Reset mid-block SHALL abandon the block without further src_pop.

Structure
REQ-034 State encoding and the 32-bit word width constant SHALL live in shared package btpipe_pkg.
REQ-035 Round-robin selection SHALL be a sub-module rr_select (request vector, pointer -> grant index, valid).

Verification
REQ-036 Reset, src0 count=256 enabled -> ARB then ARMED, ep_ready=1, active_src=0; no src_pop before ep_blockstrobe.
REQ-037 Blockstrobe then 256 ep_read -> 256 src_pop on src0, data in order at 1-cycle latency, block_done on read 256, ep_ready=0 throughout XFER.
REQ-038 Both sources count>=256 -> blocks alternate 0,1,0,1; src1 disabled -> only 0.
REQ-039 src0 count=255 -> ep_ready stays 0; count to 256 -> ep_ready=1 within 2 cycles.
REQ-040 ep_read in ARMED -> err_overrun=1, ep_datain=0; err_clr -> 0; err_clr together with a new ep_read -> flag stays 1.
REQ-041 rst_n low at word 100 of a block -> all outputs at reset values immediately; after release, arbitration restarts at source 0.
